addsub_nibble_sequencer: RTL and testbench

//   Multi-precision add/subtract controller built around the team's 4-bit add/sub cell (addsub4_structural).
//   It runs a NIBBLES*4-bit add or subtract as one nibble per cycle, LSB nibble first.

---
 rtl/addsub_nibble_sequencer_if.sv | 28 ++
 rtl/addsub_nibble_sequencer.sv | 143 ++++++++++++++
 tb/tb_addsub_nibble_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/addsub_nibble_sequencer_if.sv
// Requester <-> sequencer handshake and operand/result bundle.
// The master drives start/operands; the slave (sequencer) drives status and results.
interface addsub_nibble_sequencer_if #(
    parameter int W = 16
);
    logic         start;
    logic         subtract;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    modport master (
        output start, subtract, cin, a, b,
        input  ready, busy, done, result, carry_out, overflow, zero
    );

    modport slave (
        input  start, subtract, cin, a, b,
        output ready, busy, done, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/addsub_nibble_sequencer.sv
// Multi-precision add/subtract run one nibble per cycle through a shared 4-bit add/sub cell.
// Carry/borrow is chained between nibbles in raw (true-carry) form.

module addsub4_structural (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_sub,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [3:0] w_bx;
    logic [4:0] w_c;

    // Subtract is a + ~b with the carry-in inverted, so cin acts as borrow-in.
    assign w_bx   = i_b ^ {4{i_sub}};
    assign w_c[0] = i_cin ^ i_sub;

    for (genvar g = 0; g < 4; g++) begin : g_fa
        assign o_sum[g]   = i_a[g] ^ w_bx[g] ^ w_c[g];
        assign w_c[g+1]   = (i_a[g] & w_bx[g]) | (w_c[g] & (i_a[g] ^ w_bx[g]));
    end

    assign o_cout = w_c[4];
endmodule

module addsub_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    addsub_nibble_sequencer_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_sub;
    logic          r_creg;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_result;
    logic          r_carry_out;
    logic          r_overflow;
    logic          r_zero;

    logic          w_run;
    logic          w_accept;
    logic          w_last;
    logic [3:0]    w_cell_a;
    logic [3:0]    w_cell_b;
    logic          w_cell_sub;
    logic          w_cell_cin;
    logic [3:0]    w_cell_sum;
    logic          w_cell_cout;
    logic [W-1:0]  w_acc_final;

    assign w_run    = (r_state == S_RUN);
    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
    assign w_last   = w_run && (r_idx == LAST_IDX);

    // Cell sees zeros outside RUN so it stays quiet while idle.
    // The cell re-applies the subtract XOR to its carry-in, so pre-cancel it here.
    assign w_cell_a   = w_run ? r_a[4*r_idx +: 4] : 4'h0;
    assign w_cell_b   = w_run ? r_b[4*r_idx +: 4] : 4'h0;
    assign w_cell_sub = w_run ? r_sub : 1'b0;
    assign w_cell_cin = w_run ? (r_creg ^ r_sub) : 1'b0;

    addsub4_structural u_cell (
        .i_a    (w_cell_a),
        .i_b    (w_cell_b),
        .i_sub  (w_cell_sub),
        .i_cin  (w_cell_cin),
        .o_sum  (w_cell_sum),
        .o_cout (w_cell_cout)
    );

    // Only meaningful on the last RUN edge, when the top nibble is being produced.
    assign w_acc_final = {w_cell_sum, r_acc[W-5:0]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_creg      <= 1'b0;
            r_acc       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_sub   <= bus.subtract;
                        r_creg  <= bus.cin ^ bus.subtract;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc[4*r_idx +: 4] <= w_cell_sum;
                    r_creg              <= w_cell_cout;
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_result    <= w_acc_final;
                        r_carry_out <= w_cell_cout ^ r_sub;
                        r_overflow  <= (r_a[W-1] == (r_b[W-1] ^ r_sub)) &&
                                       (w_acc_final[W-1] != r_a[W-1]);
                        r_zero      <= (w_acc_final == '0);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign bus.busy      = w_run;
    assign bus.done      = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;
    assign bus.zero      = r_zero;
endmodule

// File: tb/tb_addsub_nibble_sequencer.sv
// Directed-vector bench for addsub_nibble_sequencer with NIBBLES=4 (16-bit operands).
module tb_addsub_nibble_sequencer;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    addsub_nibble_sequencer_if #(.W(16)) bus ();

    addsub_nibble_sequencer #(.NIBBLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic sub, input logic c,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic eco,
                          input logic eov, input logic ez);
        int n;
        @(negedge clk);
        bus.subtract = sub; bus.cin = c; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = ~a; bus.b = ~b; bus.subtract = ~sub; bus.cin = ~c;
        check({tag, "_busy"}, bus.busy, 1);
        n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_result"}, bus.result, er);
        check({tag, "_carry"}, bus.carry_out, eco);
        check({tag, "_ovf"}, bus.overflow, eov);
        check({tag, "_zero"}, bus.zero, ez);
        check({tag, "_ready"}, bus.ready, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 0);
    endtask

    initial begin
        int n;
        int seen;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.subtract = 1'b0; bus.cin = 1'b0;
        bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 16'h0000);
        check("rst_flags", {bus.carry_out, bus.overflow, bus.zero}, 3'b000);

        run_op("add_basic", 1'b0, 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap",  1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("sub_nb",    1'b1, 1'b0, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        run_op("sub_brw",   1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("add_ovf",   1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("sub_ovf",   1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("sub_cin",   1'b1, 1'b1, 16'h0005, 16'h0003, 16'h0001, 1'b0, 1'b0, 1'b0);

        // start pulsed with new operands mid-RUN must be ignored
        @(negedge clk);
        bus.subtract = 1'b0; bus.cin = 1'b0; bus.a = 16'h1234; bus.b = 16'h0FCD; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 16'hFFFF; bus.b = 16'h0001; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 2;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ign_latency", n, 4);
        check("ign_result", bus.result, 16'h2201);
        @(negedge clk);
        check("ign_idle", bus.ready & ~bus.busy, 1);

        // back-to-back: start held through DONE
        bus.subtract = 1'b0; bus.cin = 1'b0; bus.a = 16'h0001; bus.b = 16'h0002; bus.start = 1'b1;
        @(negedge clk);
        bus.a = 16'h0010; bus.b = 16'h0020;
        n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first", bus.result, 16'h0003);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 20);
        bus.start = 1'b0;
        check("b2b_period", n, 5);
        check("b2b_second", bus.result, 16'h0030);
        @(negedge clk);

        // reset after the 2nd RUN cycle
        bus.a = 16'h1111; bus.b = 16'h2222; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_ready", bus.ready, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_result", bus.result, 16'h0000);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check("mid_rst_nodone", seen, 0);

        // reset and start together: reset wins
        reset = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.start = 1'b0;
        check("rst_start_busy", bus.busy, 0);

        run_op("post_rst", 1'b1, 1'b1, 16'h0005, 16'h0003, 16'h0001, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
